// File: rtl/eth_fifo_pkg.sv
// Shared defaults, constants and helpers for the Ethernet packet FIFO.
package eth_fifo_pkg;

  localparam int    DEF_DSIZE    = 8;
  localparam int    DEF_ASIZE    = 11;
  localparam int    DEF_AFULL_TH = 16;
  localparam int    DROP_CNT_W   = 16;
  localparam string FT_TRUE      = "TRUE";
  localparam string FT_FALSE     = "FALSE";

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  // Saturate so a long run of bad frames never wraps back to a small count.
  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Single-clock storage array for the packet FIFO: one write port, one read
// port, output either fall-through or registered on each accepted read.
module pkt_fifo_mem
  import eth_fifo_pkg::*;
#(
  parameter int    WIDTH       = DEF_DSIZE + 1,
  parameter int    ASIZE       = DEF_ASIZE,
  parameter string FALLTHROUGH = FT_TRUE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic             rvalid,
  input  logic [ASIZE-1:0] raddr,
  output logic [WIDTH-1:0] rhead,
  output logic [WIDTH-1:0] rdata
);

  localparam bit REG_OUT = (FALLTHROUGH == FT_FALSE);

  logic [WIDTH-1:0] mem_q [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rhead = mem_q[raddr];

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] rdata_q, rdata_d;
      logic             unused_reg;

      assign unused_reg = rvalid;

      always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = rhead;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end else begin : g_ft
      logic unused_ft;

      assign unused_ft = re ^ rst_n;
      // Hide stale array contents while nothing committed is waiting.
      assign rdata = rvalid ? rhead : '0;
    end
  endgenerate

endmodule

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward Ethernet frame FIFO: frames become visible to the reader
// only once their last word is committed; dropped or overflowing frames rewind.
module eth_pkt_fifo
  import eth_fifo_pkg::*;
#(
  parameter int    DSIZE       = DEF_DSIZE,
  parameter int    ASIZE       = DEF_ASIZE,
  parameter string FALLTHROUGH = FT_TRUE,
  parameter int    AFULL_TH    = DEF_AFULL_TH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [DSIZE-1:0]      wdata,
  input  logic                  wlast,
  input  logic                  wdrop,
  output logic                  wfull,
  output logic                  awfull,
  input  logic                  rinc,
  output logic [DSIZE-1:0]      rdata,
  output logic                  rlast,
  output logic                  rempty,
  output logic [ASIZE:0]        frm_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int             PW        = ASIZE + 1;
  localparam logic [PW-1:0]  DEPTH     = {1'b1, {ASIZE{1'b0}}};
  localparam logic [PW-1:0]  AFULL_LIM = PW'(AFULL_TH);

  logic [PW-1:0] wptr_spec_q, wptr_spec_d;
  logic [PW-1:0] wptr_cmt_q,  wptr_cmt_d;
  logic [PW-1:0] rptr_q,      rptr_d;
  logic          ovf_q,       ovf_d;
  logic [PW-1:0] frm_cnt_q,   frm_cnt_d;
  drop_cnt_t     drop_cnt_q,  drop_cnt_d;

  logic [PW-1:0] used, free;
  logic          wr_acc, rd_acc, commit, rewind, rd_last;
  logic [DSIZE:0] mem_head, mem_rdata;

  assign used   = wptr_spec_q - rptr_q;
  assign free   = DEPTH - used;
  assign wfull  = (used == DEPTH);
  assign awfull = (free < AFULL_LIM);
  assign rempty = (rptr_q == wptr_cmt_q);

  assign wr_acc  = winc & ~wfull & ~ovf_q;
  assign rd_acc  = rinc & ~rempty;
  assign commit  = winc & wlast & ~wdrop & ~ovf_q & ~wfull;
  assign rewind  = winc & wlast & (wdrop | ovf_q | wfull);
  assign rd_last = rd_acc & mem_head[DSIZE];

  // Rewind wins over the speculative increment and the overflow set, so a
  // bad last word both discards the frame and re-arms the writer.
  always_comb begin
    wptr_spec_d = wptr_spec_q;
    wptr_cmt_d  = wptr_cmt_q;
    ovf_d       = ovf_q;
    drop_cnt_d  = drop_cnt_q;
    if (wr_acc)       wptr_spec_d = wptr_spec_q + 1'b1;
    if (winc & wfull) ovf_d = 1'b1;
    if (commit)       wptr_cmt_d = wptr_spec_q + 1'b1;
    if (rewind) begin
      wptr_spec_d = wptr_cmt_q;
      ovf_d       = 1'b0;
      drop_cnt_d  = sat_inc(drop_cnt_q);
    end
  end

  always_comb begin
    rptr_d    = rptr_q + {{ASIZE{1'b0}}, rd_acc};
    frm_cnt_d = frm_cnt_q;
    case ({commit, rd_last})
      2'b10:   frm_cnt_d = frm_cnt_q + 1'b1;
      2'b01:   frm_cnt_d = frm_cnt_q - 1'b1;
      default: frm_cnt_d = frm_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_spec_q <= '0;
      wptr_cmt_q  <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
      frm_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wptr_spec_q <= wptr_spec_d;
      wptr_cmt_q  <= wptr_cmt_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
      frm_cnt_q   <= frm_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  pkt_fifo_mem #(
    .WIDTH       (DSIZE + 1),
    .ASIZE       (ASIZE),
    .FALLTHROUGH (FALLTHROUGH)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wr_acc),
    .waddr  (wptr_spec_q[ASIZE-1:0]),
    .wdata  ({wlast, wdata}),
    .re     (rd_acc),
    .rvalid (~rempty),
    .raddr  (rptr_q[ASIZE-1:0]),
    .rhead  (mem_head),
    .rdata  (mem_rdata)
  );

  assign {rlast, rdata} = mem_rdata;
  assign frm_cnt        = frm_cnt_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Self-checking bench for eth_pkt_fifo: three instances (default fall-through,
// small fall-through, small registered) checked against a frame-queue model.
module tb_eth_pkt_fifo;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic       winc [N];
  logic       wlast[N];
  logic       wdrop[N];
  logic       rinc [N];
  logic [7:0] wdata[N];

  logic        wfull   [N];
  logic        awfull  [N];
  logic        rempty  [N];
  logic        rlast   [N];
  logic [7:0]  rdata   [N];
  logic [15:0] drop_cnt[N];
  logic [11:0] frm_cnt [N];

  logic [11:0] fc0;
  logic [4:0]  fc1, fc2;
  assign frm_cnt[0] = fc0;
  assign frm_cnt[1] = {7'd0, fc1};
  assign frm_cnt[2] = {7'd0, fc2};

  int depth[N];
  int th   [N];
  bit ft   [N];

  int errors = 0;
  int checks = 0;

  // Reference model: committed words, the frame under construction, overflow.
  logic [8:0] mq[N][$];
  logic [8:0] pq[N][$];
  bit         movf [N];
  int         mdrop[N];
  logic [8:0] mreg [N];

  always #5 clk = ~clk;

  eth_pkt_fifo #(.DSIZE(8), .ASIZE(11), .FALLTHROUGH("TRUE"), .AFULL_TH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .winc(winc[0]), .wdata(wdata[0]), .wlast(wlast[0]),
    .wdrop(wdrop[0]), .wfull(wfull[0]), .awfull(awfull[0]), .rinc(rinc[0]),
    .rdata(rdata[0]), .rlast(rlast[0]), .rempty(rempty[0]), .frm_cnt(fc0),
    .drop_cnt(drop_cnt[0]));

  eth_pkt_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("TRUE"), .AFULL_TH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .winc(winc[1]), .wdata(wdata[1]), .wlast(wlast[1]),
    .wdrop(wdrop[1]), .wfull(wfull[1]), .awfull(awfull[1]), .rinc(rinc[1]),
    .rdata(rdata[1]), .rlast(rlast[1]), .rempty(rempty[1]), .frm_cnt(fc1),
    .drop_cnt(drop_cnt[1]));

  eth_pkt_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("FALSE"), .AFULL_TH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .winc(winc[2]), .wdata(wdata[2]), .wlast(wlast[2]),
    .wdrop(wdrop[2]), .wfull(wfull[2]), .awfull(awfull[2]), .rinc(rinc[2]),
    .rdata(rdata[2]), .rlast(rlast[2]), .rempty(rempty[2]), .frm_cnt(fc2),
    .drop_cnt(drop_cnt[2]));

  function automatic int m_frames(int s);
    int n = 0;
    for (int i = 0; i < mq[s].size(); i++) if (mq[s][i][8]) n++;
    return n;
  endfunction

  function automatic int m_used(int s);
    return mq[s].size() + pq[s].size();
  endfunction

  task automatic m_step(int s, bit wi, bit wl, bit wd, logic [7:0] wv, bit ri);
    bit full = (m_used(s) == depth[s]);
    if (ri && mq[s].size() > 0) mreg[s] = mq[s].pop_front();
    if (wi) begin
      if (wl) begin
        if (wd || movf[s] || full) begin
          pq[s].delete();
          movf[s] = 1'b0;
          if (mdrop[s] < 65535) mdrop[s]++;
        end else begin
          pq[s].push_back({1'b1, wv});
          while (pq[s].size() > 0) mq[s].push_back(pq[s].pop_front());
        end
      end else if (full) begin
        movf[s] = 1'b1;
      end else if (!movf[s]) begin
        pq[s].push_back({1'b0, wv});
      end
    end
  endtask

  task automatic cyc(int s, bit wi, bit wl, bit wd, logic [7:0] wv, bit ri);
    winc[s] = wi; wlast[s] = wl; wdrop[s] = wd; wdata[s] = wv; rinc[s] = ri;
    m_step(s, wi, wl, wd, wv, ri);
    @(posedge clk); #1;
    winc[s] = 1'b0; wlast[s] = 1'b0; wdrop[s] = 1'b0; rinc[s] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int s = 0; s < N; s++) begin
      winc[s] = 1'b0; wlast[s] = 1'b0; wdrop[s] = 1'b0; rinc[s] = 1'b0; wdata[s] = 8'h00;
      mq[s].delete(); pq[s].delete(); movf[s] = 1'b0; mdrop[s] = 0; mreg[s] = 9'h000;
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < N; s++) begin
      checks++; if (rempty[s] !== 1'b1) begin errors++; $display("[TB] FAIL reset_rempty[%0d]: got %b want 1", s, rempty[s]); end
      checks++; if (wfull[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset_wfull[%0d]: got %b want 0", s, wfull[s]); end
      checks++; if (awfull[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset_awfull[%0d]: got %b want 0", s, awfull[s]); end
      checks++; if (frm_cnt[s] !== 12'd0) begin errors++; $display("[TB] FAIL reset_frm_cnt[%0d]: got %0d want 0", s, frm_cnt[s]); end
      checks++; if (drop_cnt[s] !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt[%0d]: got %0d want 0", s, drop_cnt[s]); end
    end
    checks++; if ({rlast[2], rdata[2]} !== 9'h000) begin errors++; $display("[TB] FAIL reset_rdata_reg: got %h want 000", {rlast[2], rdata[2]}); end
  endtask

  task automatic test_frame64();
    for (int i = 0; i < 64; i++) begin
      cyc(0, 1'b1, i == 63, 1'b0, 8'(i), 1'b0);
      if (i < 63) begin
        checks++; if (rempty[0] !== 1'b1) begin errors++; $display("[TB] FAIL f64_uncommitted_hidden w%0d: got rempty=%b want 1", i, rempty[0]); end
      end
    end
    checks++; if (rempty[0] !== 1'b0) begin errors++; $display("[TB] FAIL f64_rempty_after_commit: got %b want 0", rempty[0]); end
    checks++; if (frm_cnt[0] !== 12'd1) begin errors++; $display("[TB] FAIL f64_frm_cnt: got %0d want 1", frm_cnt[0]); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (rdata[0] !== 8'(i)) begin errors++; $display("[TB] FAIL f64_rdata r%0d: got %h want %h", i, rdata[0], 8'(i)); end
      checks++; if (rlast[0] !== (i == 63)) begin errors++; $display("[TB] FAIL f64_rlast r%0d: got %b want %b", i, rlast[0], i == 63); end
      cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    checks++; if (rempty[0] !== 1'b1) begin errors++; $display("[TB] FAIL f64_rempty_end: got %b want 1", rempty[0]); end
    checks++; if (frm_cnt[0] !== 12'd0) begin errors++; $display("[TB] FAIL f64_frm_cnt_end: got %0d want 0", frm_cnt[0]); end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 20; i++) cyc(0, 1'b1, i == 19, i == 19, 8'($urandom), 1'b0);
    checks++; if (rempty[0] !== 1'b1) begin errors++; $display("[TB] FAIL drop_rempty: got %b want 1", rempty[0]); end
    for (int i = 0; i < 10; i++) cyc(0, 1'b1, i == 9, 1'b0, 8'($urandom), 1'b0);
    checks++; if (drop_cnt[0] !== 16'd1) begin errors++; $display("[TB] FAIL drop_cnt: got %0d want 1", drop_cnt[0]); end
    checks++; if (frm_cnt[0] !== 12'(m_frames(0))) begin errors++; $display("[TB] FAIL drop_frm_cnt: got %0d want %0d", frm_cnt[0], m_frames(0)); end
    for (int i = 0; i < 10; i++) begin
      checks++; if ({rlast[0], rdata[0]} !== mq[0][0]) begin errors++; $display("[TB] FAIL drop_read r%0d: got %h want %h", i, {rlast[0], rdata[0]}, mq[0][0]); end
      cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    checks++; if (rempty[0] !== 1'b1) begin errors++; $display("[TB] FAIL drop_only_good_frame: got rempty=%b want 1", rempty[0]); end
  endtask

  task automatic test_overflow(int s, int pre);
    for (int i = 0; i < pre; i++) cyc(s, 1'b1, i == pre - 1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(s, 1'b1, i == 19, 1'b0, 8'($urandom), 1'b0);
      checks++; if (wfull[s] !== (m_used(s) == depth[s])) begin errors++; $display("[TB] FAIL ovf_wfull[%0d] w%0d: got %b want %b", s, i, wfull[s], m_used(s) == depth[s]); end
      checks++; if (awfull[s] !== ((depth[s] - m_used(s)) < th[s])) begin errors++; $display("[TB] FAIL ovf_awfull[%0d] w%0d: got %b want %b", s, i, awfull[s], (depth[s] - m_used(s)) < th[s]); end
      if (i == 15 - pre) begin
        checks++; if (wfull[s] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full_point[%0d]: got %b want 1", s, wfull[s]); end
      end
    end
    checks++; if (drop_cnt[s] !== 16'd1) begin errors++; $display("[TB] FAIL ovf_drop_cnt[%0d]: got %0d want 1", s, drop_cnt[s]); end
    checks++; if (wfull[s] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_wfull_after[%0d]: got %b want 0", s, wfull[s]); end
    checks++; if (rempty[s] !== (pre == 0)) begin errors++; $display("[TB] FAIL ovf_rempty[%0d]: got %b want %b", s, rempty[s], pre == 0); end
    checks++; if (frm_cnt[s] !== 12'(m_frames(s))) begin errors++; $display("[TB] FAIL ovf_frm_cnt[%0d]: got %0d want %0d", s, frm_cnt[s], m_frames(s)); end
    for (int i = 0; i < pre; i++) begin
      if (ft[s]) begin
        checks++; if ({rlast[s], rdata[s]} !== mq[s][0]) begin errors++; $display("[TB] FAIL ovf_kept_frame[%0d] r%0d: got %h want %h", s, i, {rlast[s], rdata[s]}, mq[s][0]); end
      end
      cyc(s, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      if (!ft[s]) begin
        checks++; if ({rlast[s], rdata[s]} !== mreg[s]) begin errors++; $display("[TB] FAIL ovf_kept_frame[%0d] r%0d: got %h want %h", s, i, {rlast[s], rdata[s]}, mreg[s]); end
      end
    end
  endtask

  task automatic test_wrap(int s);
    int  remaining = 0;
    bit  wi, ri, wl;
    for (int c = 0; c < 150; c++) begin
      if (remaining == 0) remaining = $urandom_range(1, 5);
      wi = ($urandom_range(0, 3) != 0);
      ri = ($urandom_range(0, 3) != 0);
      wl = wi && (remaining == 1);
      if (ft[s] && mq[s].size() > 0) begin
        checks++; if ({rlast[s], rdata[s]} !== mq[s][0]) begin errors++; $display("[TB] FAIL wrap_ft_head[%0d] c%0d: got %h want %h", s, c, {rlast[s], rdata[s]}, mq[s][0]); end
      end
      cyc(s, wi, wl, 1'b0, 8'($urandom), ri);
      if (wi) remaining--;
      if (!ft[s]) begin
        checks++; if ({rlast[s], rdata[s]} !== mreg[s]) begin errors++; $display("[TB] FAIL wrap_reg_data[%0d] c%0d: got %h want %h", s, c, {rlast[s], rdata[s]}, mreg[s]); end
      end
      checks++; if (rempty[s] !== (mq[s].size() == 0)) begin errors++; $display("[TB] FAIL wrap_rempty[%0d] c%0d: got %b want %b", s, c, rempty[s], mq[s].size() == 0); end
      checks++; if (frm_cnt[s] !== 12'(m_frames(s))) begin errors++; $display("[TB] FAIL wrap_frm_cnt[%0d] c%0d: got %0d want %0d", s, c, frm_cnt[s], m_frames(s)); end
      checks++; if (wfull[s] !== (m_used(s) == depth[s])) begin errors++; $display("[TB] FAIL wrap_wfull[%0d] c%0d: got %b want %b", s, c, wfull[s], m_used(s) == depth[s]); end
    end
    // Finish any open frame, then drain within a fixed cycle budget.
    if (remaining > 0) cyc(s, 1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int c = 0; c < 40 && mq[s].size() > 0; c++) begin
      if (ft[s]) begin
        checks++; if ({rlast[s], rdata[s]} !== mq[s][0]) begin errors++; $display("[TB] FAIL wrap_drain[%0d] c%0d: got %h want %h", s, c, {rlast[s], rdata[s]}, mq[s][0]); end
      end
      cyc(s, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      if (!ft[s]) begin
        checks++; if ({rlast[s], rdata[s]} !== mreg[s]) begin errors++; $display("[TB] FAIL wrap_drain[%0d] c%0d: got %h want %h", s, c, {rlast[s], rdata[s]}, mreg[s]); end
      end
    end
    checks++; if (rempty[s] !== 1'b1) begin errors++; $display("[TB] FAIL wrap_drained[%0d]: got rempty=%b want 1", s, rempty[s]); end
  endtask

  task automatic test_same_cycle();
    cyc(0, 1'b1, 1'b0, 1'b0, 8'hA0, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b0, 8'hB0, 1'b1);
    cyc(0, 1'b1, 1'b1, 1'b0, 8'hB1, 1'b1);
    checks++; if (frm_cnt[0] !== 12'd1) begin errors++; $display("[TB] FAIL same_cycle_frm_cnt: got %0d want 1", frm_cnt[0]); end
    checks++; if (rdata[0] !== 8'hB0) begin errors++; $display("[TB] FAIL same_cycle_head: got %h want b0", rdata[0]); end
    cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (rempty[0] !== 1'b1) begin errors++; $display("[TB] FAIL empty_read_rempty c%0d: got %b want 1", i, rempty[0]); end
      checks++; if (frm_cnt[0] !== 12'd0) begin errors++; $display("[TB] FAIL empty_read_frm_cnt c%0d: got %0d want 0", i, frm_cnt[0]); end
    end
    cyc(0, 1'b1, 1'b1, 1'b0, 8'h5C, 1'b0);
    checks++; if ({rlast[0], rdata[0]} !== 9'h15C) begin errors++; $display("[TB] FAIL empty_read_no_ptr_move: got %h want 15c", {rlast[0], rdata[0]}); end
    cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++) cyc(0, 1'b1, i == 3, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
    checks++; if (frm_cnt[0] !== 12'd2) begin errors++; $display("[TB] FAIL rst_mid_pre_frm_cnt: got %0d want 2", frm_cnt[0]); end
    do_reset();
    checks++; if (rempty[0] !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_rempty: got %b want 1", rempty[0]); end
    checks++; if (frm_cnt[0] !== 12'd0) begin errors++; $display("[TB] FAIL rst_mid_frm_cnt: got %0d want 0", frm_cnt[0]); end
    checks++; if (drop_cnt[0] !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_drop_cnt: got %0d want 0", drop_cnt[0]); end
    checks++; if (wfull[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_wfull: got %b want 0", wfull[0]); end
    cyc(0, 1'b1, 1'b1, 1'b0, 8'h3E, 1'b0);
    checks++; if ({rlast[0], rdata[0]} !== 9'h13E) begin errors++; $display("[TB] FAIL rst_mid_fresh_frame: got %h want 13e", {rlast[0], rdata[0]}); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    depth = '{2048, 16, 16};
    th    = '{16, 4, 4};
    ft    = '{1'b1, 1'b1, 1'b0};
    test_reset();
    test_frame64();
    test_drop();
    test_overflow(1, 0);
    test_overflow(2, 3);
    test_wrap(1);
    test_wrap(2);
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_pkt_fifo.md
ETH_PKT_FIFO -- requirements
Module: eth_pkt_fifo

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits.
REQ-002 Parameter ASIZE, default 11, log2 of depth in words; depth = 2^ASIZE (2048 holds one 1518-byte frame plus margin).
REQ-003 Parameter FALLTHROUGH, default "TRUE"; "TRUE" = first-word fall-through, "FALSE" = registered read data.
REQ-004 Parameter AFULL_TH, default 16, free-word threshold for awfull.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 winc  input  1  write strobe, one word per cycle.
REQ-008 wdata  input  DSIZE  write word.
REQ-009 wlast  input  1  marks the final word of a frame; qualified by winc.
REQ-010 wdrop  input  1  with winc&wlast: discard the whole frame (e.g. FCS error).
REQ-011 wfull  output  1  no free word for the in-progress write.
REQ-012 awfull  output  1  free words < AFULL_TH.
REQ-013 rinc  input  1  read strobe.
REQ-014 rdata  output  DSIZE  read word.
REQ-015 rlast  output  1  rdata is the final word of its frame.
REQ-016 rempty  output  1  no committed word available.
REQ-017 frm_cnt  output  ASIZE+1  committed frames stored, not yet fully read.
REQ-018 drop_cnt  output  16  frames discarded since reset, saturating at 0xFFFF.

Function
REQ-019 Storage SHALL be DSIZE+1 bits wide (data plus last flag); pointers wptr_spec, wptr_cmt and rptr SHALL be ASIZE+1 bits and wrap modulo 2^(ASIZE+1).
REQ-020 Accepted write = winc & ~wfull & ~ovf; it stores {wlast,wdata} at wptr_spec[ASIZE-1:0] and increments wptr_spec.
REQ-021 wfull SHALL be (wptr_spec - rptr) == 2^ASIZE, combinational from registered pointers.
REQ-022 winc while wfull SHALL set sticky flag ovf; ovf causes all further words of that frame to be ignored.
REQ-023 On winc&wlast with ~wdrop & ~ovf & ~wfull: wptr_cmt <= wptr_spec+1 (commit).
REQ-024 On winc&wlast with wdrop | ovf | wfull: wptr_spec <= wptr_cmt (rewind), ovf cleared, drop_cnt incremented.
REQ-025 Read side SHALL see only committed words: rempty = (rptr == wptr_cmt); a committed frame becomes readable the cycle after its wlast edge.
REQ-026 Accepted read = rinc & ~rempty; rinc while rempty SHALL be ignored with no state change.
REQ-027 FALLTHROUGH "TRUE": rdata/rlast SHALL show mem[rptr] whenever ~rempty; rptr advances on accepted read.
REQ-028 FALLTHROUGH "FALSE": rdata/rlast SHALL register mem[rptr] on the accepted-read edge (one-cycle latency) and hold otherwise.
REQ-029 frm_cnt SHALL +1 on commit, -1 on accepted read of a word with last flag; both in one cycle leaves it unchanged.
REQ-030 awfull SHALL be (2^ASIZE - (wptr_spec - rptr)) < AFULL_TH.
REQ-031 Simultaneous write and read SHALL both be accepted when their own conditions hold; freed space is visible to wfull the next cycle.
REQ-032 A frame longer than 2^ASIZE words SHALL be dropped via REQ-022/024 and leave previously committed frames intact.

Reset
REQ-033 While rst_n=0 at a clk edge: all pointers, ovf, frm_cnt, drop_cnt <= 0; rdata, rlast <= 0; hence wfull=0, awfull=0, rempty=1.
REQ-034 Reset mid-frame or mid-read SHALL discard all contents; memory array need not be cleared.

Structure
REQ-035 Shared package eth_fifo_pkg SHALL hold default DSIZE/ASIZE, drop-counter width and the FALLTHROUGH string constants.
REQ-036 Storage SHALL be a sub-module pkt_fifo_mem (single-clock, one write port, one read port, FALLTHROUGH-selectable output register); pointer/commit logic stays in eth_pkt_fifo.

Verification
REQ-037 Write 64-byte frame 0x00..0x3F, wdrop=0 -> rempty falls next cycle, frm_cnt=1, reads return 0x00..0x3F with rlast only on 0x3F, then rempty=1, frm_cnt=0.
REQ-038 Write 20-byte frame with wdrop=1 on last, then a 10-byte good frame -> drop_cnt=1, reader sees only the 10-byte frame.
REQ-039 ASIZE=4: write 20-word frame -> wfull at word 16, ovf, drop_cnt=1, rempty stays 1, pointers back to 0.
REQ-040 Continuous write/read across pointer wrap (3x depth) with FALLTHROUGH "TRUE" and "FALSE" -> data order intact, "FALSE" data one cycle after rinc.
REQ-041 Commit and last-word read in same cycle -> frm_cnt unchanged; rinc while rempty -> no pointer change.
REQ-042 rst_n low mid-frame with 2 committed frames -> rempty=1, frm_cnt=0, drop_cnt=0, wfull=0 after the edge.
